code_sender: RTL and testbench
==============================

Name: code_sender

Overview:
Serial key-code transmitter that drives the single-bit entry line of the sequence-detecting digital lock. It holds a programmable code and shifts it out MSB first, one bit per clock. It then watches the lock's unlock output and retries a bounded number of times before reporting failure. It sits between a controller (start/load handshake) and the lock's serial input.

Parameters:
CODE_W, 4, code length in bits (2..8)
DEFAULT_CODE, 4'b1101, code register value after reset (CODE_W bits)
ACK_TIMEOUT, 4, cycles spent waiting for unlock_in after the last bit (1..15)
MAX_TRIES, 3, total attempts before fail (1..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
code_load  input  1  load code_in into the code register (honoured in IDLE only)
code_in  input  CODE_W  new code value
start  input  1  begin an unlock sequence (honoured in IDLE only)
unlock_in  input  1  lock's open indication
out_seq  output  1  serial bit to the lock's input; registered
busy  output  1  high in every state except IDLE; registered
done  output  1  one-cycle pulse: unlock seen
fail  output  1  one-cycle pulse: all attempts timed out
attempts  output  4  attempts started in the current/last operation

Behaviour:
- Reset (rst=1 at a clock edge, any state including mid-operation): state=IDLE, out_seq=0, busy=0, done=0, fail=0, attempts=0, code register=DEFAULT_CODE, all counters cleared.
- FSM states: IDLE, FLUSH, SEND, WAIT. All outputs are registered and reflect the current state.
- IDLE: out_seq=0, busy=0.
  - code_load=1 → code register <= code_in.
  - start=1 → attempts <= 1, go to FLUSH.
  - If start and code_load are both high in the same cycle, the load takes effect and the attempt uses the new code.
  - attempts holds its last value in IDLE; it is cleared only by reset or by the next start.
- FLUSH: exactly CODE_W cycles with out_seq=0. This drives any partially advanced lock back to its initial state. Then go to SEND.
- SEND: exactly CODE_W cycles, out_seq = code bit CODE_W-1 down to 0. Use a shift copy so the code register is unchanged. Then go to WAIT.
- WAIT: out_seq=0, for up to ACK_TIMEOUT cycles. The first WAIT cycle is the cycle immediately after the last SEND bit.
  - unlock_in=1 in any WAIT cycle → go to IDLE; done=1 in the following cycle only.
  - Timeout with attempts<MAX_TRIES → attempts++, go to FLUSH.
  - Timeout with attempts==MAX_TRIES → go to IDLE; fail=1 in the following cycle only.
- unlock_in is ignored outside WAIT.
- start and code_load are ignored while busy=1.
- done and fail are mutually exclusive and never asserted together with busy=1.
- Timing from start sampled at edge E0, per attempt:
  - FLUSH occupies cycles E0+1..E0+CODE_W.
  - SEND occupies E0+CODE_W+1..E0+2*CODE_W.
  - WAIT begins at E0+2*CODE_W+1.
  - Attempt period = 2*CODE_W+ACK_TIMEOUT cycles.
- attempts saturates at MAX_TRIES; no wrap.

Test Plan:
1. Reset, default code 1101, start at cycle 0, lock model attached → out_seq cycles 1-8 = 0,0,0,0,1,1,0,1; unlock_in=1 at cycle 9; done=1 at cycle 10 only; attempts=1; busy cycles 1-9.
2. unlock_in held 0 → three attempts of 12 cycles each (FLUSH, SEND, WAIT) → fail=1 at cycle 37 only; attempts=3; done never asserted; out_seq=0 outside SEND windows.
3. code_load with code_in=1011 in IDLE, then start → SEND bits 1,0,1,1; reset afterwards → code reverts to 1101 (verified by next start).
4. start and code_load(0110) pulsed during SEND → stream unchanged, no restart, code register unchanged; start and code_load(0110) asserted in the same IDLE cycle → sends 0110.
5. rst=1 on the second SEND cycle → next cycle out_seq=0, busy=0, attempts=0; no done or fail pulse.
6. Lock model rejects the first attempt, accepts the second → done at cycle 22 (one cycle after unlock_in at cycle 21, the first WAIT cycle of attempt 2); attempts=2; unlock_in pulse injected during FLUSH is ignored.

Source files
------------

// File: rtl/code_sender.sv
// Serial key-code transmitter for the sequence-detecting lock: flushes the lock,
// shifts the code out MSB first, then waits for unlock with bounded retries.
module code_sender #(
    parameter int                CODE_W       = 4,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = 4'b1101,
    parameter int                ACK_TIMEOUT  = 4,
    parameter int                MAX_TRIES    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_load,
    input  logic [CODE_W-1:0] code_in,
    input  logic              start,
    input  logic              unlock_in,
    output logic              out_seq,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [3:0]        attempts
);

    typedef enum logic [1:0] {IDLE, FLUSH, SEND, WAIT} state_t;

    localparam logic [3:0] LAST_BIT  = 4'(CODE_W - 1);
    localparam logic [3:0] LAST_WAIT = 4'(ACK_TIMEOUT - 1);
    localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [CODE_W-1:0] code_reg, code_nxt;
    logic [CODE_W-1:0] shreg, sh_nxt;
    logic [3:0]        att_nxt;
    logic              out_nxt, busy_nxt, done_nxt, fail_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            code_reg <= DEFAULT_CODE;
            shreg    <= '0;
            attempts <= '0;
            out_seq  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            code_reg <= code_nxt;
            shreg    <= sh_nxt;
            attempts <= att_nxt;
            out_seq  <= out_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            fail     <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 4'd1;
        code_nxt  = code_reg;
        sh_nxt    = shreg;
        att_nxt   = attempts;
        done_nxt  = 1'b0;
        fail_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (code_load) code_nxt = code_in;
                if (start) begin
                    att_nxt   = 4'd1;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt == LAST_BIT) begin
                    state_nxt = SEND;
                    cnt_nxt   = '0;
                    // Send from a working copy so the stored code survives retries.
                    sh_nxt    = code_reg;
                end
            end
            SEND: begin
                sh_nxt = {shreg[CODE_W-2:0], 1'b0};
                if (cnt == LAST_BIT) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (unlock_in) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (cnt == LAST_WAIT) begin
                    cnt_nxt = '0;
                    if (attempts < TRIES_MAX) begin
                        att_nxt   = attempts + 4'd1;
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = IDLE;
                        fail_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        out_nxt  = (state_nxt == SEND) ? sh_nxt[CODE_W-1] : 1'b0;
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_code_sender.sv
// Bench for code_sender: table of whole operations plus randomized operations,
// each checked cycle by cycle against a timeline model derived from the attempt period.
module tb_code_sender;

    localparam int W = 4;
    localparam int T = 4;
    localparam int M = 3;
    localparam int P = 2 * W + T;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         code_load = 1'b0;
    logic [W-1:0] code_in = '0;
    logic         start = 1'b0;
    logic         unlock_in = 1'b0;
    logic         out_seq, busy, done, fail;
    logic [3:0]   attempts;

    int           nvec = 0;
    int           nerr = 0;
    logic [W-1:0] model_code;

    code_sender #(.CODE_W(W), .DEFAULT_CODE(4'b1101), .ACK_TIMEOUT(T), .MAX_TRIES(M)) dut (
        .clk(clk), .rst(rst), .code_load(code_load), .code_in(code_in), .start(start),
        .unlock_in(unlock_in), .out_seq(out_seq), .busy(busy), .done(done), .fail(fail),
        .attempts(attempts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         do_rst;
        logic [W-1:0] code;
        logic         load;
        int           acc_att;
        int           acc_off;
        logic         noise;
        int           exp_done;
        int           exp_fail;
        int           exp_att;
    } vec_t;

    task automatic chk(input string name, input int t, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; code_load = 1'b0; unlock_in = 1'b0;
        @(negedge clk);
        chk("rst_out_seq", 0, int'(out_seq), 0);
        chk("rst_busy", 0, int'(busy), 0);
        chk("rst_done", 0, int'(done), 0);
        chk("rst_fail", 0, int'(fail), 0);
        chk("rst_attempts", 0, int'(attempts), 0);
        rst = 1'b0;
        model_code = 4'b1101;
    endtask

    // Called at a negedge with the DUT idle. acc_att = 0 means the lock never opens.
    task automatic run_op(input logic [W-1:0] code, input logic load, input int acc_att,
                          input int acc_off, input logic noise,
                          output int done_at, output int fail_at, output int last_att);
        logic [W-1:0] ucode;
        int L, a, ph, eo, eb, ea, ed, ef;
        bit acc;
        acc = (acc_att > 0);
        if (load) model_code = code;
        ucode = model_code;
        L = acc ? (acc_att - 1) * P + 2 * W + acc_off + 1 : M * P;
        done_at = -1; fail_at = -1; last_att = -1;
        start = 1'b1; code_load = load; code_in = code; unlock_in = 1'b0;
        for (int t = 1; t <= L + 3; t++) begin
            @(negedge clk);
            a = (t - 1) / P;
            ph = (t - 1) % P;
            if (t <= L) begin
                eb = 1; ea = a + 1; ed = 0; ef = 0;
                eo = (ph >= W && ph < 2 * W) ? int'(ucode[W - 1 - (ph - W)]) : 0;
            end else begin
                eb = 0; eo = 0; ea = acc ? acc_att : M;
                ed = (acc && t == L + 1) ? 1 : 0;
                ef = (!acc && t == L + 1) ? 1 : 0;
            end
            chk("out_seq", t, int'(out_seq), eo);
            chk("busy", t, int'(busy), eb);
            chk("attempts", t, int'(attempts), ea);
            chk("done", t, int'(done), ed);
            chk("fail", t, int'(fail), ef);
            if (done && done_at < 0) done_at = t;
            if (fail && fail_at < 0) fail_at = t;
            last_att = int'(attempts);
            if (t <= L) begin
                start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                code_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                code_in   = W'($urandom);
                if (acc && t == L) unlock_in = 1'b1;
                else if (ph >= 2 * W) unlock_in = 1'b0;
                else unlock_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                start = 1'b0; code_load = 1'b0; unlock_in = 1'b0;
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        int d, f, la;
        vecs[0] = '{1'b0, 4'b0000, 1'b0, 1, 0, 1'b0, 10, -1, 1};
        vecs[1] = '{1'b0, 4'b0000, 1'b0, 0, 0, 1'b0, -1, 37, 3};
        vecs[2] = '{1'b0, 4'b1011, 1'b1, 1, 2, 1'b0, 12, -1, 1};
        vecs[3] = '{1'b1, 4'b0000, 1'b0, 1, 0, 1'b1, 10, -1, 1};
        vecs[4] = '{1'b0, 4'b0110, 1'b1, 3, 3, 1'b1, 37, -1, 3};
        vecs[5] = '{1'b0, 4'b0000, 1'b0, 2, 0, 1'b1, 22, -1, 2};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_rst) do_reset();
            run_op(vecs[i].code, vecs[i].load, vecs[i].acc_att, vecs[i].acc_off,
                   vecs[i].noise, d, f, la);
            chk("tbl_done_cycle", i, d, vecs[i].exp_done);
            chk("tbl_fail_cycle", i, f, vecs[i].exp_fail);
            chk("tbl_attempts", i, la, vecs[i].exp_att);
        end

        // Reset on the second SEND cycle aborts the operation silently.
        start = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_send_bit", 6, int'(out_seq), int'(model_code[W-2]));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_code = 4'b1101;
        chk("abort_out_seq", 7, int'(out_seq), 0);
        chk("abort_busy", 7, int'(busy), 0);
        chk("abort_attempts", 7, int'(attempts), 0);
        for (int t = 8; t < 28; t++) begin
            @(negedge clk);
            chk("abort_done", t, int'(done), 0);
            chk("abort_fail", t, int'(fail), 0);
            chk("abort_busy_idle", t, int'(busy), 0);
        end

        // The default code must be back after that reset.
        run_op(4'b0000, 1'b0, 1, 1, 1'b0, d, f, la);
        chk("post_rst_done", 0, d, 11);

        for (int r = 0; r < 30; r++) begin
            int acc, off;
            acc = $urandom_range(0, M);
            off = $urandom_range(0, T - 1);
            run_op(W'($urandom), 1'($urandom_range(0, 1)), acc, off, 1'b1, d, f, la);
            chk("rnd_done_cycle", r, d, acc > 0 ? (acc - 1) * P + 2 * W + off + 2 : -1);
            chk("rnd_fail_cycle", r, f, acc > 0 ? -1 : M * P + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
